wormhole_output_ctrl: RTL

Output-port controller for the NoC router, directly downstream of `round_robin_arb`. It exposes input-port flit-valid lines as the arbiter's request vector and consumes the one-hot grant. It locks the granted input for a whole wormhole packet, head flit through tail flit, and moves that input's flits into a registered output stage with a valid/ready handshake toward the link.

---
 rtl/wormhole_output_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/wormhole_output_ctrl.sv
// Wormhole output-port controller: locks one arbiter-granted input from head to tail flit
// and moves its flits into a registered valid/ready output stage. Optional watchdog: WORMHOLE_TIMEOUT_EN.
module wormhole_output_ctrl #(
    parameter int num_Agents     = 4,
    parameter int Flit_Width     = 32,
    parameter int Timeout_Cycles = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [num_Agents-1:0]              in_valid,
    input  logic [num_Agents*Flit_Width-1:0]   in_flit,
    input  logic [num_Agents-1:0]              in_tail,
    output logic [num_Agents-1:0]              in_ready,
    output logic [num_Agents-1:0]              request,
    input  logic [num_Agents-1:0]              grant,
    output logic                               out_valid,
    output logic [Flit_Width-1:0]              out_flit,
    output logic                               out_tail,
    input  logic                               out_ready,
    output logic                               timeout_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [num_Agents-1:0]   owner_q, owner_d;
    logic                    out_valid_q;
    logic [Flit_Width-1:0]   out_flit_q;
    logic                    out_tail_q;
    logic                    terr_q, terr_d;

    logic                    can_load;
    logic                    grant_ok;
    logic                    owner_vld;
    logic                    xfer;
    logic [Flit_Width-1:0]   sel_flit;
    logic                    sel_tail;

    // Owner is one-hot, so an OR of masked lanes is the owner's flit.
    always_comb begin
        sel_flit = '0;
        sel_tail = 1'b0;
        for (int i = 0; i < num_Agents; i++) begin
            if (owner_q[i]) begin
                sel_flit = sel_flit | in_flit[i*Flit_Width +: Flit_Width];
                sel_tail = sel_tail | in_tail[i];
            end
        end
    end

    assign can_load  = !out_valid_q || out_ready;
    assign owner_vld = |(in_valid & owner_q);
    assign grant_ok  = (grant != '0) && ((grant & (grant - 1'b1)) == '0) &&
                       ((grant & in_valid) != '0);

`ifdef WORMHOLE_TIMEOUT_EN
    localparam int CNT_W = $clog2(Timeout_Cycles + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = Timeout_Cycles;
`endif

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        request  = '0;
        in_ready = '0;
        xfer     = 1'b0;
        terr_d   = 1'b0;
`ifdef WORMHOLE_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                request = in_valid;
`ifdef WORMHOLE_TIMEOUT_EN
                cnt_d   = '0;
`endif
                if (grant_ok) begin
                    owner_d = grant;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (can_load) in_ready = owner_q;
                xfer = owner_vld && can_load;
                if (xfer && sel_tail) begin
                    state_d = IDLE;
                    owner_d = '0;
                end
`ifdef WORMHOLE_TIMEOUT_EN
                // Only cycles with no owner flit offered count as stalled.
                if (xfer) begin
                    cnt_d = '0;
                end else if (!owner_vld) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(Timeout_Cycles)) begin
                        state_d = IDLE;
                        owner_d = '0;
                        terr_d  = 1'b1;
                        cnt_d   = '0;
                    end
                end
`endif
            end
            default: begin
                state_d = IDLE;
                owner_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            out_tail_q  <= 1'b0;
            terr_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            terr_q  <= terr_d;
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_flit_q  <= sel_flit;
                out_tail_q  <= sel_tail;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef WORMHOLE_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign out_flit  = out_flit_q;
    assign out_tail  = out_tail_q;

endmodule
